// File: rtl/just_pass_pkg.sv
// Shared constants, the per-item mode enum and the lane parity helper for the
// just_pass_pipe multi-lane elastic pipeline.
package just_pass_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int LANES_DEF      = 2;
  localparam int DEPTH_DEF      = 3;
  localparam int CNT_WIDTH_DEF  = 16;

  // Widest lane the parity helper accepts; narrower lanes are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int LANE_MAX_W = 64;

  typedef enum logic {
    PASS   = 1'b0,
    INVERT = 1'b1
  } mode_e;

  // Odd parity of one lane: 1 when the lane holds an odd number of ones.
  function automatic logic lane_parity(input logic [LANE_MAX_W-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/just_pass_pipe_if.sv
// Upstream and downstream valid/ready handshake of just_pass_pipe.
// The pipeline connects through the slave modport, its driver through master.
interface just_pass_pipe_if
  import just_pass_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = LANES_DEF
);

  logic                        in_valid;
  logic                        in_ready;
  logic                        mode_i;
  logic [LANES*DATA_WIDTH-1:0] data_i;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*DATA_WIDTH-1:0] data_o;
  logic [LANES-1:0]            bool_o;

  modport master (
    output in_valid, mode_i, data_i, out_ready,
    input  in_ready, out_valid, data_o, bool_o
  );

  modport slave (
    input  in_valid, mode_i, data_i, out_ready,
    output in_ready, out_valid, data_o, bool_o
  );

endinterface

// File: rtl/just_pass_stage.sv
// One elastic pipeline stage: a {valid, data, parity} register that loads
// from its predecessor whenever it is empty or its own content is leaving.
module just_pass_stage #(
  parameter int W     = 16,
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [W-1:0]     up_data,
  input  logic [LANES-1:0] up_parity,
  input  logic             advance,
  output logic             valid,
  output logic [W-1:0]     data,
  output logic [LANES-1:0] parity,
  output logic             ready
);

  // Room for a new item: nothing held, or the held item leaves this edge.
  assign ready = !valid || advance;

  // Load on ready, hold while stalled; an empty stage keeps its last data.
  always_ff @(posedge clk) begin
    // NOTE: data and parity are reset too, because they are visible on the
    // outputs and must read 0 straight after reset.
    if (rst) begin
      // NOTE: non-blocking assignments so every stage samples its
      // predecessor's pre-edge value and items shift by exactly one stage.
      valid  <= 1'b0;
      data   <= '0;
      parity <= '0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data   <= up_data;
        parity <= up_parity;
      end
    end
  end

endmodule

// File: rtl/just_pass_pipe.sv
// Multi-lane elastic pass-through pipeline: optional inversion at entry,
// per-lane parity carried with the data, DEPTH stages with combinational
// ready propagation, registered occupancy and a wrapping transfer counter.
module just_pass_pipe
  import just_pass_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  localparam int W         = LANES * DATA_WIDTH,
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  just_pass_pipe_if.slave      bus,
  output logic [OCC_W-1:0]     occupancy_o,
  output logic [CNT_WIDTH-1:0] pass_cnt_o
);

  mode_e            mode;
  logic [W-1:0]     entry_data;
  logic [LANES-1:0] entry_parity;
  logic             in_ready;
  logic             in_xfer;
  logic             out_xfer;

  assign mode = mode_e'(bus.mode_i);

  // Transform at entry; parity is taken on the transformed lanes.
  always_comb begin
    entry_data   = (mode == INVERT) ? ~bus.data_i : bus.data_i;
    entry_parity = '0;
    for (int l = 0; l < LANES; l++) begin
      entry_parity[l] = lane_parity(LANE_MAX_W'(entry_data[l*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // Each block owns its own handshake nets so the backward ready chain is a
  // plain series of separate signals rather than bits of one vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [W-1:0]     up_data;
    logic [LANES-1:0] up_parity;
    logic             adv;
    logic             valid;
    logic [W-1:0]     data;
    logic [LANES-1:0] parity;
    logic             rdy;

    if (i == 0) begin : g_head
      assign up_valid  = in_xfer;
      assign up_data   = entry_data;
      assign up_parity = entry_parity;
    end else begin : g_body
      assign up_valid  = g_stage[i-1].valid;
      assign up_data   = g_stage[i-1].data;
      assign up_parity = g_stage[i-1].parity;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign adv = bus.out_ready;
    end else begin : g_mid
      assign adv = g_stage[i+1].rdy;
    end

    just_pass_stage #(
      .W     (W),
      .LANES (LANES)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .up_valid  (up_valid),
      .up_data   (up_data),
      .up_parity (up_parity),
      .advance   (adv),
      .valid     (valid),
      .data      (data),
      .parity    (parity),
      .ready     (rdy)
    );
  end

  // Nothing is accepted while reset is asserted, whatever the stages hold.
  assign in_ready      = g_stage[0].rdy && !rst;
  assign in_xfer       = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = g_stage[DEPTH-1].valid;
  assign bus.data_o    = g_stage[DEPTH-1].data;
  assign bus.bool_o    = g_stage[DEPTH-1].parity;
  assign out_xfer      = bus.out_valid && bus.out_ready;

  // Occupancy tracks the stage valids; the counter counts output transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy_o <= '0;
      pass_cnt_o  <= '0;
    end else begin
      occupancy_o <= occupancy_o + OCC_W'(in_xfer) - OCC_W'(out_xfer);
      if (out_xfer) begin
        pass_cnt_o <= pass_cnt_o + 1'b1;
      end
    end
  end

endmodule
